// File: rtl/aer_in_tx.sv
// AER input-link transmitter: buffers host spike addresses in a small FIFO and
// drives them onto the core's AERIN port with a 4-phase REQ/ACK handshake.
module aer_in_tx #(
    parameter int AER_WIDTH   = 12,
    parameter int FIFO_DEPTH  = 16,
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EVT_VALID,
    input  logic [AER_WIDTH-1:0] EVT_ADDR,
    input  logic                 EVT_LAST,
    output logic                 EVT_READY,
    output logic [AER_WIDTH-1:0] AERIN_ADDR,
    output logic                 AERIN_REQ,
    input  logic                 AERIN_ACK,
    output logic                 BUSY,
    output logic                 TX_DONE,
    output logic [CNT_WIDTH-1:0] EVT_CNT,
    output logic                 TIMEOUT_ERR,
    output logic [2:0]           FSM_STATE
);

    // Handshake: a FIFO entry moves on EVT_VALID && EVT_READY at a rising edge.
    // On the AER side REQ rises only after one address-setup cycle, falls on the
    // edge ACK=1 is sampled, and the event completes on the edge ACK=0 is sampled.

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_REQ_HI = 3'd2,
        S_REQ_LO = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [AER_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr, rd_ptr;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;
    logic [AER_WIDTH:0]   fifo_head;

    logic [AER_WIDTH-1:0] addr_q;
    logic                 last_q;
    logic                 req_q;
    logic                 done_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 sample_end_q;
    logic                 err_q;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 tmo_hit;
    logic                 hs_done, tmo_clr, tmo_inc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign push       = EVT_VALID && !fifo_full;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {EVT_LAST, EVT_ADDR};
    end

    // The counter reaches ACK_TIMEOUT on the edge that leaves for ERR.
    assign tmo_hit = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (!fifo_empty) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_REQ_HI;
            S_REQ_HI: begin
                if (AERIN_ACK)    state_nx = S_REQ_LO;
                else if (tmo_hit) state_nx = S_ERR;
            end
            S_REQ_LO: begin
                if (!AERIN_ACK)   state_nx = fifo_empty ? S_IDLE : S_SETUP;
                else if (tmo_hit) state_nx = S_ERR;
            end
            S_ERR:    state_nx = S_ERR;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        hs_done = 1'b0;
        tmo_clr = 1'b0;
        tmo_inc = 1'b0;
        case (state)
            S_IDLE:   pop = !fifo_empty;
            S_SETUP:  tmo_clr = 1'b1;
            S_REQ_HI: begin
                if (AERIN_ACK) tmo_clr = 1'b1;
                else           tmo_inc = 1'b1;
            end
            S_REQ_LO: begin
                if (!AERIN_ACK) begin
                    hs_done = 1'b1;
                    pop     = !fifo_empty;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            addr_q       <= '0;
            last_q       <= 1'b0;
            req_q        <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            sample_end_q <= 1'b0;
            err_q        <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            req_q  <= (state_nx == S_REQ_HI);
            done_q <= hs_done && last_q;
            if (pop) begin
                addr_q <= fifo_head[AER_WIDTH-1:0];
                last_q <= fifo_head[AER_WIDTH];
            end
            // A completion after a sample boundary starts the next sample at 1.
            if (hs_done) begin
                sample_end_q <= last_q;
                if (sample_end_q)      cnt_q <= CNT_WIDTH'(1);
                else if (cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
            end
            if (state_nx == S_ERR) err_q <= 1'b1;
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign EVT_READY   = !fifo_full;
    assign AERIN_ADDR  = addr_q;
    assign AERIN_REQ   = req_q;
    assign BUSY        = (state != S_IDLE) || !fifo_empty;
    assign TX_DONE     = done_q;
    assign EVT_CNT     = cnt_q;
    assign TIMEOUT_ERR = err_q;
    assign FSM_STATE   = state;

endmodule
